// File: rtl/pe_os_mac.sv
// pe_os_mac: output-stationary systolic PE with registered operand forwarding,
// two-stage saturating MAC, sticky overflow and a result drain shift chain.
module pe_os_mac #(
  parameter int W_WIDTH   = 4,
  parameter int A_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter bit W_SIGNED  = 1'b1,
  parameter bit A_SIGNED  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_WIDTH-1:0]   w_in,
  input  logic                 w_valid_in,
  input  logic [A_WIDTH-1:0]   a_in,
  input  logic                 a_valid_in,
  input  logic                 first_in,
  output logic [W_WIDTH-1:0]   w_out,
  output logic                 w_valid_out,
  output logic [A_WIDTH-1:0]   a_out,
  output logic                 a_valid_out,
  output logic                 first_out,
  input  logic                 drain_load,
  input  logic                 drain_shift,
  input  logic [ACC_WIDTH-1:0] psum_in,
  output logic [ACC_WIDTH-1:0] psum_out,
  output logic                 ovf_out,
  output logic [ACC_WIDTH-1:0] acc_out
);
  logic signed [ACC_WIDTH-1:0] w_w_ext, w_a_ext, w_prod, r_prod, w_acc_next;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_fire, w_sat, r_p_valid, r_p_first;
  assign w_fire  = w_valid_in & a_valid_in;
  // the sign bit is replicated only in signed mode, otherwise zeros
  assign w_w_ext = {{(ACC_WIDTH-W_WIDTH){W_SIGNED & w_in[W_WIDTH-1]}}, w_in};
  assign w_a_ext = {{(ACC_WIDTH-A_WIDTH){A_SIGNED & a_in[A_WIDTH-1]}}, a_in};
  assign w_prod  = w_w_ext * w_a_ext;
  assign w_sum   = {acc_out[ACC_WIDTH-1], acc_out} + {r_prod[ACC_WIDTH-1], r_prod};
  // overflow when the extra sum bit disagrees with the result sign; clamp toward the true sign
  assign w_sat      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_acc_next = w_sat ? {w_sum[ACC_WIDTH], {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}}
                            : w_sum[ACC_WIDTH-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_out       <= '0;
      w_valid_out <= 1'b0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
      first_out   <= 1'b0;
      r_prod      <= '0;
      r_p_valid   <= 1'b0;
      r_p_first   <= 1'b0;
      acc_out     <= '0;
      ovf_out     <= 1'b0;
      psum_out    <= '0;
    end else begin
      w_out       <= w_in;
      w_valid_out <= w_valid_in;
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      first_out   <= first_in;
      r_p_valid   <= w_fire;
      if (w_fire) begin
        r_prod    <= w_prod;
        r_p_first <= first_in;
      end
      if (r_p_valid) begin
        acc_out <= r_p_first ? r_prod : w_acc_next;
        ovf_out <= ~r_p_first & (ovf_out | w_sat);
      end
      if (drain_load) psum_out <= acc_out;
      else if (drain_shift) psum_out <= psum_in;
    end
  end
endmodule

// File: tb/tb_pe_os_mac.sv
// tb_pe_os_mac: directed checks of the PE against an arithmetic reference model,
// plus unsigned, narrow-accumulator saturation and a four-PE drain chain.
module tb_pe_os_mac;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // main instance: default signed parameters
  logic [3:0]  w0 = '0, wo0;
  logic [7:0]  a0 = '0, ao0;
  logic        wv0 = 0, av0 = 0, f0 = 0, dl0 = 0, ds0 = 0, wvo0, avo0, fo0, ovf0;
  logic [23:0] psi0 = '0, pso0, acc0;
  pe_os_mac u0 (.clk(clk), .rst(rst), .w_in(w0), .w_valid_in(wv0), .a_in(a0), .a_valid_in(av0),
    .first_in(f0), .w_out(wo0), .w_valid_out(wvo0), .a_out(ao0), .a_valid_out(avo0),
    .first_out(fo0), .drain_load(dl0), .drain_shift(ds0), .psum_in(psi0), .psum_out(pso0),
    .ovf_out(ovf0), .acc_out(acc0));

  // unsigned instance
  logic [3:0]  w1 = '0, wo1;
  logic [7:0]  a1 = '0, ao1;
  logic        v1 = 0, f1 = 0, wvo1, avo1, fo1, ovf1;
  logic [23:0] pso1, acc1;
  pe_os_mac #(.W_SIGNED(1'b0), .A_SIGNED(1'b0)) u1 (.clk(clk), .rst(rst), .w_in(w1),
    .w_valid_in(v1), .a_in(a1), .a_valid_in(v1), .first_in(f1), .w_out(wo1),
    .w_valid_out(wvo1), .a_out(ao1), .a_valid_out(avo1), .first_out(fo1), .drain_load(1'b0),
    .drain_shift(1'b0), .psum_in(24'd0), .psum_out(pso1), .ovf_out(ovf1), .acc_out(acc1));

  // narrow accumulator instance for saturation
  logic [3:0]  w2 = '0, wo2;
  logic [7:0]  a2 = '0, ao2;
  logic        v2 = 0, f2 = 0, wvo2, avo2, fo2, ovf2;
  logic [11:0] pso2, acc2;
  pe_os_mac #(.ACC_WIDTH(12)) u2 (.clk(clk), .rst(rst), .w_in(w2), .w_valid_in(v2), .a_in(a2),
    .a_valid_in(v2), .first_in(f2), .w_out(wo2), .w_valid_out(wvo2), .a_out(ao2),
    .a_valid_out(avo2), .first_out(fo2), .drain_load(1'b0), .drain_shift(1'b0),
    .psum_in(12'd0), .psum_out(pso2), .ovf_out(ovf2), .acc_out(acc2));

  // four-PE drain chain; ps[0] feeds the head, ps[4] is the tail output
  logic [7:0]  ac[4];
  logic        vc = 0, fc = 0, dlc = 0, dsc = 0;
  logic [23:0] ps[5];
  logic [3:0]  wco[4];
  logic [7:0]  aco[4];
  logic        wvco[4], avco[4], fco[4], ovfc[4];
  logic [23:0] accc[4];
  assign ps[0] = '0;
  for (genvar g = 0; g < 4; g++) begin : g_chain
    pe_os_mac uc (.clk(clk), .rst(rst), .w_in(4'd1), .w_valid_in(vc), .a_in(ac[g]),
      .a_valid_in(vc), .first_in(fc), .w_out(wco[g]), .w_valid_out(wvco[g]), .a_out(aco[g]),
      .a_valid_out(avco[g]), .first_out(fco[g]), .drain_load(dlc), .drain_shift(dsc),
      .psum_in(ps[g]), .psum_out(ps[g+1]), .ovf_out(ovfc[g]), .acc_out(accc[g]));
  end

  // reference model for u0: products land one edge after sampling, then add-and-clamp
  localparam longint HI = (64'sd1 <<< 23) - 1, LO = -(64'sd1 <<< 23);
  logic [3:0] m_w;
  logic [7:0] m_a;
  logic       m_wv, m_av, m_f, m_ovf, m_pend, m_pend_first;
  longint     m_acc, m_psum, m_pend_prod;

  function automatic longint clamp(input longint s);
    return s > HI ? HI : (s < LO ? LO : s);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_w, m_a, m_wv, m_av, m_f, m_ovf, m_pend, m_pend_first} <= '0;
      m_acc <= 0;
      m_psum <= 0;
      m_pend_prod <= 0;
    end else begin
      m_w <= w0; m_a <= a0; m_wv <= wv0; m_av <= av0; m_f <= f0;
      m_psum <= dl0 ? m_acc : (ds0 ? longint'($signed(psi0)) : m_psum);
      if (m_pend) begin
        m_acc <= m_pend_first ? m_pend_prod : clamp(m_acc + m_pend_prod);
        m_ovf <= m_pend_first ? 1'b0 : (m_ovf | (clamp(m_acc + m_pend_prod) != m_acc + m_pend_prod));
      end
      m_pend <= wv0 & av0;
      if (wv0 & av0) begin
        m_pend_prod  <= longint'($signed(w0)) * longint'($signed(a0));
        m_pend_first <= f0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("w_out", wo0, m_w);
      chk("w_valid_out", wvo0, m_wv);
      chk("a_out", ao0, m_a);
      chk("a_valid_out", avo0, m_av);
      chk("first_out", fo0, m_f);
      chk("acc_out", $signed(acc0), m_acc);
      chk("ovf_out", ovf0, m_ovf);
      chk("psum_out", $signed(pso0), m_psum);
    end
  end

  task automatic op0(input logic v, input logic [3:0] w, input logic [7:0] a, input logic f);
    wv0 = v; av0 = v; w0 = w; a0 = a; f0 = f;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ac[i] = 8'(10 * (i + 1));
    tick(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    // nonzero activity, then async reset mid-cycle
    op0(1, 4'd5, 8'd9, 1);
    op0(1, 4'd3, 8'd2, 0);
    dl0 = 1; psi0 = 24'd77;
    op0(0, 4'd6, 8'd11, 1);
    dl0 = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_w_out", wo0, 0);
    chk("rst_a_out", ao0, 0);
    chk("rst_valids", {wvo0, avo0, fo0}, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_psum", pso0, 0);
    chk("rst_ovf", ovf0, 0);
    wv0 = 0; av0 = 0; f0 = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("no_acc_without_fire", acc0, 0);
    // first fire after reset accumulates onto zero without first_in
    op0(1, 4'd2, 8'd3, 0);
    op0(0, 4'd0, 8'd0, 0);
    chk("post_rst_fire", $signed(acc0), 6);
    // signed dot product
    op0(1, 4'b1000, 8'd127, 1);
    op0(1, 4'd7, 8'b1000_0000, 0);
    op0(1, 4'd3, 8'd5, 0);
    op0(0, 4'd0, 8'd0, 0);
    chk("signed_dot", $signed(acc0), -1897);
    chk("signed_dot_ovf", ovf0, 0);
    // valid gaps: weight valid drops every other cycle
    for (int i = 0; i < 6; i++) begin
      wv0 = i[0]; av0 = 1; w0 = 4'(i + 1); a0 = 8'(i * 3 + 1); f0 = 0;
      tick();
    end
    op0(0, 4'd0, 8'd0, 0);
    tick();
    chk("gapped_dot", $signed(acc0), -1897 + 2 * 4 + 4 * 10 + 6 * 16);
    // drain_load with a new first-tagged fire in the same cycle captures the old tile
    dl0 = 1;
    op0(1, 4'd1, 8'd1, 1);
    dl0 = 0;
    chk("overlap_capture", $signed(pso0), -1897 + 144);
    op0(0, 4'd0, 8'd0, 0);
    chk("overlap_new_tile", $signed(acc0), 1);
    dl0 = 1; ds0 = 1; psi0 = 24'd12345;
    tick();
    chk("load_beats_shift", $signed(pso0), 1);
    dl0 = 0;
    tick();
    chk("shift_only", $signed(pso0), 12345);
    ds0 = 0;
    // unsigned mode
    w1 = 4'hF; a1 = 8'hFF; v1 = 1; f1 = 1;
    tick();
    f1 = 0;
    tick(3);
    v1 = 0;
    tick(2);
    chk("unsigned_dot", acc1, 15300);
    // saturation at 12 bits, sticky until next first fire
    w2 = 4'd7; a2 = 8'd127; v2 = 1; f2 = 1;
    tick();
    f2 = 0;
    tick(3);
    v2 = 0;
    tick(2);
    chk("sat_clamp", $signed(acc2), 2047);
    chk("sat_ovf", ovf2, 1);
    tick(3);
    chk("sat_ovf_sticky", ovf2, 1);
    w2 = 4'd1; a2 = 8'd5; v2 = 1; f2 = 1;
    tick();
    v2 = 0; f2 = 0;
    tick(2);
    chk("sat_new_tile", $signed(acc2), 5);
    chk("sat_ovf_cleared", ovf2, 0);
    // drain chain
    vc = 1; fc = 1;
    tick();
    vc = 0; fc = 0;
    tick(2);
    dlc = 1;
    tick();
    dlc = 0;
    chk("chain_0", ps[4], 40);
    dsc = 1;
    tick();
    chk("chain_1", ps[4], 30);
    tick();
    chk("chain_2", ps[4], 20);
    tick();
    chk("chain_3", ps[4], 10);
    dsc = 0;
    cmp_en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
